// File: rtl/demux_pipe_stage.sv
// Registered 1-to-N write demultiplexer with a 2-entry skid buffer.
// Writes aimed at the hardwired zero lane are accepted, dropped and counted.
module demux_pipe_stage #(
    parameter int unsigned SEL_W    = 5,
    parameter int unsigned N_OUT    = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ZERO_IDX = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_en,
    output logic [SEL_W-1:0]  out_sel,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_e;

    typedef struct packed {
        logic [N_OUT-1:0]  en;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Setting ZERO_IDX to N_OUT (or above) makes every lane writable.
    localparam bit               DISCARD_ON = (ZERO_IDX < N_OUT);
    localparam logic [SEL_W-1:0] ZERO_SEL   = SEL_W'(ZERO_IDX);

    fill_e      fill_q, fill_d;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [7:0] drop_q, drop_d;

    entry_t new_entry;
    logic   is_zero;
    logic   push;
    logic   store;
    logic   discard;
    logic   pop;

    // Decode happens before the flops so the lane enables leave straight from registers.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        new_entry      = '0;
        new_entry.sel  = in_sel;
        new_entry.data = in_data;
        for (int i = 0; i < int'(N_OUT); i++) begin
            new_entry.en[i] = (in_sel == SEL_W'(i));
        end
    end

    assign is_zero = DISCARD_ON && (in_sel == ZERO_SEL);
    assign push    = in_valid && in_ready;
    assign store   = push && !is_zero;
    assign discard = push && is_zero;
    assign pop     = out_valid && out_ready;

    always_comb begin
        fill_d = fill_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (fill_q)
            EMPTY: begin
                if (store) begin
                    head_d = new_entry;
                    fill_d = ONE;
                end
            end
            ONE: begin
                case ({store, pop})
                    2'b10: begin
                        tail_d = new_entry;
                        fill_d = FULL;
                    end
                    2'b11: head_d = new_entry;
                    2'b01: begin
                        head_d = '0;
                        fill_d = EMPTY;
                    end
                    default: ;
                endcase
            end
            FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    tail_d = '0;
                    fill_d = ONE;
                end
            end
            default: begin
                fill_d = EMPTY;
                head_d = '0;
                tail_d = '0;
            end
        endcase
    end

    assign drop_d = (discard && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the two entries are cleared on reset because their contents drive the output pins directly.
            fill_q <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
            drop_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            fill_q <= fill_d;
            head_q <= head_d;
            tail_q <= tail_d;
            drop_q <= drop_d;
        end
    end

    // in_ready looks only at the registered fill level, never at out_ready.
    assign in_ready  = (fill_q != FULL) && reset_n;
    assign out_valid = (fill_q != EMPTY);
    assign out_en    = head_q.en;
    assign out_sel   = head_q.sel;
    assign out_data  = head_q.data;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_pipe_stage.sv
// Self-checking bench for demux_pipe_stage: directed scenarios plus a random
// run against a queue-based reference model.
module tb_demux_pipe_stage;

    typedef struct packed {
        logic [4:0]  sel;
        logic [63:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_sel = '0;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_en;
    logic [4:0]  out_sel;
    logic [63:0] out_data;
    logic [7:0]  drop_cnt;

    logic        nz_in_valid = 1'b0;
    logic        nz_in_ready;
    logic [4:0]  nz_in_sel = '0;
    logic [63:0] nz_in_data = '0;
    logic        nz_out_valid;
    logic        nz_out_ready = 1'b1;
    logic [31:0] nz_out_en;
    logic [4:0]  nz_out_sel;
    logic [63:0] nz_out_data;
    logic [7:0]  nz_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t m_q[$];
    int   m_drop = 0;

    demux_pipe_stage #(.SEL_W(5), .N_OUT(32), .DATA_W(64), .ZERO_IDX(31)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_en(out_en),
        .out_sel(out_sel), .out_data(out_data), .drop_cnt(drop_cnt)
    );

    demux_pipe_stage #(.SEL_W(5), .N_OUT(32), .DATA_W(64), .ZERO_IDX(32)) dut_nz (
        .clk(clk), .reset_n(reset_n),
        .in_valid(nz_in_valid), .in_ready(nz_in_ready), .in_sel(nz_in_sel), .in_data(nz_in_data),
        .out_valid(nz_out_valid), .out_ready(nz_out_ready), .out_en(nz_out_en),
        .out_sel(nz_out_sel), .out_data(nz_out_data), .drop_cnt(nz_drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one cycle of stimulus and advances the reference model across the edge.
    task automatic tick(input logic v, input logic [4:0] s, input logic [63:0] d, input logic r);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        do_push = v && (m_q.size() < 2);
        do_pop  = (m_q.size() > 0) && r;
        @(posedge clk);
        if (do_pop) m_q.delete(0);
        if (do_push) begin
            if (s == 5'd31) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
            else m_q.push_back(ent_t'{s, d});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) tick(1'b0, 5'd0, 64'd0, 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: out_valid/in_ready=%b required 00", {out_valid, in_ready});
        end
        n_tests++;
        if (out_en !== 32'h0 || out_sel !== 5'd0 || out_data !== 64'd0 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%h sel=%0d data=%h drop=%0d required all zero",
                     out_en, out_sel, out_data, drop_cnt);
        end
        reset_n = 1'b1;
        m_q.delete();
        m_drop = 0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_single_write();
        tick(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b1);
        n_tests++;
        if (out_valid !== 1'b1 || out_en !== 32'h0000_0020 || out_sel !== 5'd5 || out_data !== 64'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_write: valid=%b en=%h sel=%0d data=%h required 1 00000020 5 deadbeef",
                     out_valid, out_en, out_sel, out_data);
        end
        tick(1'b0, 5'd0, 64'd0, 1'b1);
        n_tests++;
        if (out_valid !== 1'b0 || out_en !== 32'h0) begin
            n_fail++;
            $display("FAIL single_write_pop: valid=%b en=%h required 0 00000000", out_valid, out_en);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_seq[3];
        exp_seq[0] = 5'd1; exp_seq[1] = 5'd2; exp_seq[2] = 5'd3;
        tick(1'b1, 5'd1, 64'h11, 1'b0);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_one: in_ready=%b required 1", in_ready);
        end
        tick(1'b1, 5'd2, 64'h22, 1'b0);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_full: in_ready=%b required 0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 5'd3, 64'h33, 1'b0);
            n_tests++;
            if (out_valid !== 1'b1 || out_sel !== 5'd1 || out_en !== 32'h2 || out_data !== 64'h11) begin
                n_fail++;
                $display("FAIL bp_head_stable: valid=%b sel=%0d en=%h data=%h required 1 1 00000002 11",
                         out_valid, out_sel, out_en, out_data);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_sel !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: valid=%b sel=%0d required 1 %0d", i, out_valid, out_sel, exp_seq[i]);
            end
            tick(1'b1, 5'd3, 64'h33, 1'b1);
            if (i == 1) in_valid = 1'b0;
        end
        drain();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 5'(i), 64'(i * 3 + 1), 1'b1);
            n_tests++;
            if (out_valid !== 1'b1 || out_sel !== 5'(i) || out_data !== 64'(i * 3 + 1) || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream[%0d]: valid=%b sel=%0d data=%0d ready=%b required 1 %0d %0d 1",
                         i, out_valid, out_sel, out_data, in_ready, i, i * 3 + 1);
            end
        end
        drain();
    endtask

    task automatic test_discard();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 5'd31, 64'hBAD, 1'b1);
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL discard_hold[%0d]: valid=%b ready=%b required 0 1", i, out_valid, in_ready);
            end
        end
        tick(1'b1, 5'd4, 64'h44, 1'b1);
        n_tests++;
        if (out_valid !== 1'b1 || out_en !== 32'h10 || drop_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL discard_then_write: valid=%b en=%h drop=%0d required 1 00000010 3",
                     out_valid, out_en, drop_cnt);
        end
        for (int i = 0; i < 300; i++) tick(1'b1, 5'd31, 64'hBAD, 1'b1);
        n_tests++;
        if (drop_cnt !== 8'd255 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL discard_saturate: drop=%0d valid=%b required 255 0", drop_cnt, out_valid);
        end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] exp_en;
        logic [4:0]  s;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            tick(1'($urandom_range(0, 3) != 0), s, {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
            exp_en = '0;
            if (m_q.size() > 0) exp_en[m_q[0].sel] = 1'b1;
            n_tests++;
            if (out_valid !== (m_q.size() != 0) || in_ready !== (m_q.size() != 2) ||
                out_en !== exp_en || drop_cnt !== 8'(m_drop)) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: valid=%b ready=%b en=%h drop=%0d required %b %b %h %0d",
                         i, out_valid, in_ready, out_en, drop_cnt,
                         m_q.size() != 0, m_q.size() != 2, exp_en, m_drop);
            end
            if (m_q.size() > 0) begin
                n_tests++;
                if (out_sel !== m_q[0].sel || out_data !== m_q[0].data) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: sel=%0d data=%h required %0d %h",
                             i, out_sel, out_data, m_q[0].sel, m_q[0].data);
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 5'd7, 64'h77, 1'b0);
        tick(1'b1, 5'd8, 64'h88, 1'b0);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_full: ready=%b valid=%b required 0 1", in_ready, out_valid);
        end
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_en !== 32'h0 || in_ready !== 1'b0 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b en=%h ready=%b drop=%0d required 0 00000000 0 0",
                     out_valid, out_en, in_ready, drop_cnt);
        end
        m_q.delete();
        m_drop = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
        tick(1'b1, 5'd9, 64'h99, 1'b1);
        n_tests++;
        if (out_valid !== 1'b1 || out_sel !== 5'd9 || out_en !== 32'h200 || out_data !== 64'h99) begin
            n_fail++;
            $display("FAIL mid_push: valid=%b sel=%0d en=%h data=%h required 1 9 00000200 99",
                     out_valid, out_sel, out_en, out_data);
        end
        drain();
    endtask

    task automatic test_no_zero_lane();
        nz_in_valid = 1'b1;
        nz_in_sel   = 5'd31;
        nz_in_data  = 64'd7;
        @(posedge clk);
        @(negedge clk);
        nz_in_valid = 1'b0;
        n_tests++;
        if (nz_out_valid !== 1'b1 || nz_out_en !== 32'h8000_0000 || nz_out_data !== 64'd7 || nz_drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL nz_write31: valid=%b en=%h data=%0d drop=%0d required 1 80000000 7 0",
                     nz_out_valid, nz_out_en, nz_out_data, nz_drop_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_write();
        test_backpressure();
        test_stream();
        test_discard();
        test_random();
        test_reset_mid();
        test_no_zero_lane();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_pipe_stage.md
Name: demux_pipe_stage

Overview:
- Registered 1-to-N demultiplexer stage: inverse of the 2:1 select mux. Takes one data word plus a select index and steers it to one of N lanes as a one-hot enable with shared data.
- Sits between the writeback stage and the register-file write port.
- Provides a 2-entry skid buffer with valid/ready flow control.
- Discards writes to the hardwired zero register and counts them.

Parameters:
- SEL_W, 5, select index width.
- N_OUT, 32, number of output lanes; must equal 2**SEL_W.
- DATA_W, 64, data width.
- ZERO_IDX, 31, lane index whose writes are discarded; set to N_OUT to disable discarding.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream write request present.
- in_ready  output  1  stage can accept a request this cycle.
- in_sel  input  SEL_W  destination lane index.
- in_data  input  DATA_W  write data.
- out_valid  output  1  head entry presented to downstream.
- out_ready  input  1  downstream accepts head entry this cycle.
- out_en  output  N_OUT  one-hot lane enable for head entry; all zero when out_valid=0.
- out_sel  output  SEL_W  binary index of head entry.
- out_data  output  DATA_W  data of head entry.
- drop_cnt  output  8  saturating count of discarded ZERO_IDX writes.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - Buffer emptied (count=0); all entries and drop_cnt cleared to 0.
  - out_valid=0, out_en=0, out_sel=0, out_data=0.
  - in_ready forced 0 while reset_n=0.
  - Reset asserted mid-operation discards all buffered entries immediately.
- Accept: push occurs on a rising edge when in_valid && in_ready.
  - in_sel is decoded to one-hot at push; the stored entry holds the one-hot, in_sel and in_data. Output pins are driven directly from entry registers, with no decode after the flops.
- Discard: a push with in_sel==ZERO_IDX completes the handshake but stores nothing. drop_cnt increments by 1 and saturates at 255, never wrapping.
- Pop: occurs on a rising edge when out_valid && out_ready.
- Flags:
  - out_valid = (count != 0).
  - in_ready = (count != 2) && reset_n. It depends only on registered count, so there is no combinational path from out_ready.
- Latency: an entry pushed at edge k into an empty buffer is visible on the outputs after edge k. It can be popped at edge k+1. Throughput is 1 per cycle with out_ready held high.
- Order: strict FIFO. The head is the oldest stored entry; the second entry becomes head after a pop.
- Stability: while out_valid && !out_ready, out_en/out_sel/out_data must not change.
- Count transitions:
  - count=0: push → 1; discarded push → 0.
  - count=1: push only → 2; pop only → 0; push+pop same edge → 1, new entry becomes head; discarded push+pop → 0.
  - count=2: in_ready=0, no push possible; pop → 1.
- One-hot invariant: out_en has exactly one bit set when out_valid=1, and that bit is never ZERO_IDX (when ZERO_IDX < N_OUT). out_en is zero otherwise.
- in_sel, in_data and out_ready are don't-care when the corresponding valid is 0.

Test Plan:
- Reset then single write: release reset_n, in_valid=1, in_sel=5, in_data=64'hDEAD_BEEF for one cycle, out_ready=1 → next cycle out_valid=1, out_en=32'h0000_0020, out_sel=5, out_data=DEAD_BEEF; the cycle after, out_valid=0.
- Backpressure/full: out_ready=0, push sel=1,2,3 back-to-back → in_ready drops to 0 after two pushes, the third is held off; head stays sel=1 stable. Raise out_ready → outputs are 1, 2, 3 in order, one per cycle.
- Simultaneous push/pop at count=1: stream sel=0..7 with in_valid=out_ready=1 continuously → out_sel 0..7 on consecutive cycles, in_ready stays 1, no gaps.
- Zero-register discard: push sel=31 three times, then sel=4 → in_ready stays 1, out_valid only for sel=4 (out_en=32'h10), drop_cnt=3. Then 300 sel=31 pushes → drop_cnt=255.
- Reset mid-operation: buffer full (count=2) with out_ready=0, assert reset_n=0 asynchronously mid-cycle → out_valid, out_en, in_ready go 0 immediately, drop_cnt=0. After release, the buffer is empty and the next push appears normally.
- ZERO_IDX=N_OUT build: push sel=31, data=7 → out_en=32'h8000_0000, out_data=7, drop_cnt stays 0.
